// File: rtl/tickdiv_pkg.sv
// tickdiv_pkg: shared widths, the divisor typedef and standard-rate divisors
// for tick_divider. The divisor constants assume a 50 MHz system clock.
package tickdiv_pkg;

  localparam int CNT_W_DEF = 28;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // A divisor D gives a period of D+1 cycles.
  function automatic div_t period_to_div(input int unsigned cycles);
    return div_t'(cycles - 1);
  endfunction

  localparam div_t DIV_1HZ   = div_t'(49_999_999);
  localparam div_t DIV_10HZ  = div_t'(4_999_999);
  localparam div_t DIV_100HZ = div_t'(499_999);
  localparam div_t DIV_1KHZ  = div_t'(49_999);
  localparam div_t DIV_10KHZ = div_t'(4_999);

endpackage

// File: rtl/tickdiv_channel.sv
// tickdiv_channel: one divider channel (divisor, counter, tick strobe and,
// with TICKDIV_SQUARE_EN defined, the square-wave toggle flop).
import tickdiv_pkg::*;

module tickdiv_channel #(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o
`ifdef TICKDIV_SQUARE_EN
  ,output logic            sq_o
`endif
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             term;

  // cnt never passes div, so equality is the only terminal condition needed
  assign term = (cnt_q == div_q);

  // Next state: write beats disable beats terminal count beats count
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (wr_i) begin
      div_d = wr_div_i;
      cnt_d = '0;
    end else if (!en_i) begin
      cnt_d = cnt_q;
    end else if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= DIV_RST;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef TICKDIV_SQUARE_EN
  logic sq_q, sq_d;

  // Square output flips exactly when a tick is being issued
  always_comb begin
    sq_d = sq_q;
    if (!wr_i && en_i && term) sq_d = ~sq_q;
  end

  // Square toggle flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sq_q <= 1'b0;
    else       sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tick_divider.sv
// tick_divider: NUM_CH independent synchronous dividers on one clock, each
// producing a one-cycle tick used as a clock enable downstream.
// Define TICKDIV_SQUARE_EN to add the sq_o square outputs.
import tickdiv_pkg::*;

module tick_divider #(
  parameter int               NUM_CH  = 4,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '1,
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] tick_o
`ifdef TICKDIV_SQUARE_EN
  ,output logic [NUM_CH-1:0] sq_o
`endif
);

  // Indices past the last channel (non power-of-two NUM_CH) are dropped
  logic wr_ok;
  assign wr_ok = wr_en_i && (int'(wr_ch_i) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_ok && (wr_ch_i == CH_W'(i));

    tickdiv_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i[i]),
      .wr_i     (wr_sel),
      .wr_div_i (wr_div_i),
      .tick_o   (tick_o[i])
`ifdef TICKDIV_SQUARE_EN
      ,.sq_o    (sq_o[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: directed scenarios plus randomized traffic, checked
// against a model that counts enabled edges since the last restart.
module tb_tick_divider;

  localparam int N = 5;
  localparam int W = 8;
  localparam logic [W-1:0] DRST = 8'd255;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] en_i;
  logic         wr_en_i;
  logic [2:0]   wr_ch_i;
  logic [W-1:0] wr_div_i;
  logic [N-1:0] tick_o;
`ifdef TICKDIV_SQUARE_EN
  logic [N-1:0] sq_o;
`endif

  tick_divider #(.NUM_CH(N), .CNT_W(W), .DIV_RST(DRST)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .wr_en_i  (wr_en_i),
    .wr_ch_i  (wr_ch_i),
    .wr_div_i (wr_div_i),
    .tick_o   (tick_o)
`ifdef TICKDIV_SQUARE_EN
    ,.sq_o    (sq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: period D+1 means a tick on every enabled edge whose running count
  // since the last write/reset is a multiple of D+1; sq is the tick parity.
  int unsigned  mdiv [N];
  int unsigned  mn   [N];
  logic [N-1:0] mtick;
  logic [N-1:0] msq;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdiv[i] = DRST;
      mn[i]   = 0;
    end
    mtick = '0;
    msq   = '0;
  endtask

  task automatic step(input logic [N-1:0] en, input logic we,
                      input logic [2:0] ch, input logic [W-1:0] d);
    en_i = en; wr_en_i = we; wr_ch_i = ch; wr_div_i = d;
    @(posedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (we && int'(ch) == i) begin
        mdiv[i] = d; mn[i] = 0; mtick[i] = 1'b0;
      end else if (!en[i]) begin
        mtick[i] = 1'b0;
      end else begin
        mn[i]    = mn[i] + 1;
        mtick[i] = (mn[i] % (mdiv[i] + 1)) == 0;
        if (mtick[i]) msq[i] = ~msq[i];
      end
    end
    #1;
    wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    rst_i = 1'b1; en_i = '0; wr_en_i = 1'b0; wr_ch_i = '0; wr_div_i = '0;
    model_reset();
    #3;
    n_cmp++;
    if (tick_o !== '0) begin n_err++; $display("FAIL reset_tick got=%b want=0", tick_o); end
`ifdef TICKDIV_SQUARE_EN
    n_cmp++;
    if (sq_o !== '0) begin n_err++; $display("FAIL reset_sq got=%b want=0", sq_o); end
`endif
    @(negedge clk_i); rst_i = 1'b0;
    first = 0;
    for (int k = 1; k <= 300; k++) begin
      step('1, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL reset_run k=%0d tick=%b want=%b", k, tick_o, mtick); end
`ifdef TICKDIV_SQUARE_EN
      n_cmp++;
      if (sq_o !== msq) begin n_err++; $display("FAIL reset_run_sq k=%0d sq=%b want=%b", k, sq_o, msq); end
`endif
      if (tick_o[0] && first == 0) first = k;
    end
    n_cmp++;
    if (first != 256) begin n_err++; $display("FAIL first_tick edge=%0d want=256", first); end
  endtask

  task automatic test_write_d3();
    step('1, 1'b1, 3'd1, 8'd3);
    for (int k = 1; k <= 16; k++) begin
      step('1, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o[1] !== (k % 4 == 0)) begin n_err++; $display("FAIL d3_tick1 k=%0d got=%b want=%b", k, tick_o[1], (k % 4 == 0)); end
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL d3_all k=%0d tick=%b want=%b", k, tick_o, mtick); end
`ifdef TICKDIV_SQUARE_EN
      n_cmp++;
      if (sq_o !== msq) begin n_err++; $display("FAIL d3_sq k=%0d sq=%b want=%b", k, sq_o, msq); end
`endif
    end
  endtask

  task automatic test_d0();
    step('1, 1'b1, 3'd2, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step('1, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o[2] !== 1'b1) begin n_err++; $display("FAIL d0_high k=%0d got=%b want=1", k, tick_o[2]); end
`ifdef TICKDIV_SQUARE_EN
      n_cmp++;
      if (sq_o !== msq) begin n_err++; $display("FAIL d0_sq k=%0d sq=%b want=%b", k, sq_o, msq); end
`endif
    end
    step(5'b11011, 1'b0, 3'd0, 8'd0);
    n_cmp++;
    if (tick_o[2] !== 1'b0) begin n_err++; $display("FAIL d0_drop got=%b want=0", tick_o[2]); end
    n_cmp++;
    if (tick_o !== mtick) begin n_err++; $display("FAIL d0_drop_all tick=%b want=%b", tick_o, mtick); end
  endtask

  task automatic test_pause();
    int ticks;
    ticks = 0;
    step('1, 1'b1, 3'd1, 8'd4);
    for (int k = 0; k < 19; k++) begin
      // two enabled edges, seven with ch1 paused, then ten enabled
      step((k >= 2 && k < 9) ? 5'b11101 : 5'b11111, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL pause k=%0d tick=%b want=%b", k, tick_o, mtick); end
      if (tick_o[1]) ticks++;
    end
    n_cmp++;
    if (ticks != 2) begin n_err++; $display("FAIL pause_count got=%0d want=2", ticks); end
  endtask

  task automatic test_write_terminal();
    step('1, 1'b1, 3'd3, 8'd2);
    step('1, 1'b0, 3'd0, 8'd0);
    step('1, 1'b0, 3'd0, 8'd0);
    // cnt[3] now equals div[3]; the write must suppress the tick
    step('1, 1'b1, 3'd3, 8'd5);
    n_cmp++;
    if (tick_o[3] !== 1'b0) begin n_err++; $display("FAIL wr_term got=%b want=0", tick_o[3]); end
    for (int k = 1; k <= 12; k++) begin
      step('1, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL wr_term_run k=%0d tick=%b want=%b", k, tick_o, mtick); end
    end
    for (int k = 0; k < 9; k++) begin
      step('1, 1'b1, 3'(5 + k % 3), 8'($urandom_range(0, 3)));
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL oob_write k=%0d tick=%b want=%b", k, tick_o, mtick); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(N'($urandom) | N'($urandom), ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 9)));
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL random k=%0d tick=%b want=%b", k, tick_o, mtick); end
`ifdef TICKDIV_SQUARE_EN
      n_cmp++;
      if (sq_o !== msq) begin n_err++; $display("FAIL random_sq k=%0d sq=%b want=%b", k, sq_o, msq); end
`endif
    end
  endtask

  task automatic test_async_reset();
    int first;
    step('1, 1'b1, 3'd2, 8'd0);
    step('1, 1'b0, 3'd0, 8'd0);
    step('1, 1'b0, 3'd0, 8'd0);
    step('1, 1'b0, 3'd0, 8'd0);
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (tick_o !== '0) begin n_err++; $display("FAIL async_tick got=%b want=0", tick_o); end
`ifdef TICKDIV_SQUARE_EN
    n_cmp++;
    if (sq_o !== '0) begin n_err++; $display("FAIL async_sq got=%b want=0", sq_o); end
`endif
    @(negedge clk_i); rst_i = 1'b0;
    first = 0;
    for (int k = 1; k <= 260; k++) begin
      step('1, 1'b0, 3'd0, 8'd0);
      n_cmp++;
      if (tick_o !== mtick) begin n_err++; $display("FAIL async_run k=%0d tick=%b want=%b", k, tick_o, mtick); end
      if (tick_o[2] && first == 0) first = k;
    end
    n_cmp++;
    if (first != 256) begin n_err++; $display("FAIL async_div ch2 first=%0d want=256", first); end
  endtask

  initial begin
    test_reset();
    test_write_d3();
    test_d0();
    test_pause();
    test_write_terminal();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
